// File: rtl/arb_pkg.sv
// Shared types, default sizes and the rotate helper for the round-robin scheduler.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned N_DEF        = 8;
  localparam int unsigned MAX_HOLD_DEF = 4;
  localparam int unsigned N_MAX        = 16;
  localparam int unsigned IDX_W        = 4;

  // Rotate the low n bits of vec right by amt; bits at and above n come back as zero.
  function automatic logic [N_MAX-1:0] rotr(input logic [N_MAX-1:0] vec,
                                            input int unsigned amt,
                                            input int unsigned n);
    logic [N_MAX-1:0] r;
    logic [IDX_W-1:0] src;
    r = '0;
    for (int unsigned i = 0; i < N_MAX; i++) begin
      src = IDX_W'((i + amt) % n);
      if (i < n) r[IDX_W'(i)] = vec[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between the requesters and the round-robin scheduler.
interface rr_grant_scheduler_if
  import arb_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned IDW = $clog2(N)
);

  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           forced;

  modport master (
    output req, done,
    input  gnt, gnt_id, gnt_valid, forced
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, gnt_valid, forced
  );

endinterface

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder; pos is 0 when no bit is set.
module prio_enc_lsb #(
  parameter int unsigned N   = 8,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   vec,
  output logic [IDW-1:0] pos,
  output logic           any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    pos = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) pos = IDW'(i);
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: rotated lowest-first arbitration, grant held until done,
// request drop, or tenure limit, with same-edge re-arbitration on release.
module rr_grant_scheduler
  import arb_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned IDW      = $clog2(N),
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input logic                  clk,
  input logic                  areset_n,
  rr_grant_scheduler_if.slave  bus
);

  localparam int unsigned HCW = $clog2(MAX_HOLD) + 1;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic           valid_q, valid_d;
  logic           forced_q, forced_d;

  logic [IDW-1:0] arb_ptr;
  logic [N-1:0]   rot;
  logic [IDW-1:0] enc_pos;
  logic           enc_any;
  logic [IDW-1:0] win;
  logic           rel_done, rel_drop, rel_lim;

  // On a release edge the pointer moves past the current owner before arbitrating.
  assign arb_ptr  = (state_q == BUSY) ? id_q + IDW'(1) : ptr_q;
  assign rot      = N'(rotr(N_MAX'(bus.req), 32'(arb_ptr), N));
  assign win      = enc_pos + arb_ptr;

  assign rel_done = bus.done;
  assign rel_drop = ~bus.req[id_q];
  assign rel_lim  = (hold_q == HCW'(MAX_HOLD - 1));

  prio_enc_lsb #(.N(N), .IDW(IDW)) u_enc (
    .vec (rot),
    .pos (enc_pos),
    .any (enc_any)
  );

  // Next-state, grant and tenure logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    forced_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d = BUSY;
          gnt_d   = N'(1) << win;
          id_d    = win;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (rel_done || rel_drop || rel_lim) begin
          ptr_d    = id_q + IDW'(1);
          hold_d   = '0;
          forced_d = rel_lim && !rel_done && !rel_drop;
          if (enc_any) begin
            gnt_d = N'(1) << win;
            id_d  = win;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
          end
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = |gnt_d;
  end

  // State, pointer, tenure counter and output registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      id_q     <= '0;
      valid_q  <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      forced_q <= forced_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = valid_q;
  assign bus.forced    = forced_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler (N=8, MAX_HOLD=4).
module tb_rr_grant_scheduler;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       forced;
  } vec_t;

  logic clk;
  logic areset_n;
  int   checks;
  int   errors;

  vec_t tbl[$];
  vec_t expq[$];

  rr_grant_scheduler_if #(.N(8), .IDW(3)) bus ();

  rr_grant_scheduler #(.N(8), .IDW(3), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic rst, logic [7:0] req, logic done,
                              logic [7:0] gnt, logic [2:0] id, logic valid, logic forced);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done;
    v.gnt = gnt; v.id = id; v.valid = valid; v.forced = forced;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t e);
    chk({tag, ".gnt"},    32'(bus.gnt),       32'(e.gnt));
    chk({tag, ".id"},     32'(bus.gnt_id),    32'(e.id));
    chk({tag, ".valid"},  32'(bus.gnt_valid), 32'(e.valid));
    chk({tag, ".forced"}, 32'(bus.forced),    32'(e.forced));
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset_n = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    @(negedge clk);
    chk_outs("reset", mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    areset_n = 1'b1;
  endtask

  task automatic step(input int k, input vec_t v);
    vec_t e;
    if (v.rst) do_reset();
    @(negedge clk);
    bus.req  = v.req;
    bus.done = v.done;
    expq.push_back(v);
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      chk($sformatf("step%0d.queue", k), 32'd0, 32'd1);
    end else begin
      e = expq.pop_front();
      chk_outs($sformatf("step%0d", k), e);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    areset_n = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;

    // Idle after reset
    tbl.push_back(mk(1, 8'h00, 0, 8'h00, 3'd0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 8'h00, 0, 8'h00, 3'd0, 0, 0));
    // Grant 2, done moves pointer to 3, next winner 5 with no bubble, then drop to idle
    tbl.push_back(mk(0, 8'h24, 0, 8'h04, 3'd2, 1, 0));
    tbl.push_back(mk(0, 8'h24, 1, 8'h20, 3'd5, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 3'd0, 0, 0));
    // Sole requester held past the tenure limit: 4 cycles, forced pulse, re-grant
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 8'h01, 0, 8'h01, 3'd0, 1, 0));
    tbl.push_back(mk(0, 8'h01, 0, 8'h01, 3'd0, 1, 1));
    tbl.push_back(mk(0, 8'h01, 0, 8'h01, 3'd0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 3'd0, 0, 0));
    // Everyone requesting with done every cycle: 0..7 then wrap to 0
    for (int i = 0; i < 9; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << (i % 8);
      tbl.push_back(mk((i == 0), 8'hFF, 1, oh, 3'(i % 8), 1, 0));
    end
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 3'd0, 0, 0));
    // Request drop together with done: single release, no forced, idle
    tbl.push_back(mk(0, 8'h10, 0, 8'h10, 3'd4, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 8'h00, 3'd0, 0, 0));
    // Done coinciding with the tenure limit: not forced, re-granted
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 8'h10, 0, 8'h10, 3'd4, 1, 0));
    tbl.push_back(mk(0, 8'h10, 1, 8'h10, 3'd4, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 3'd0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) step(k, tbl[k]);

    // Asynchronous reset in the middle of a grant to requester 7 (pointer is 5 here)
    @(negedge clk);
    bus.req  = 8'h80;
    bus.done = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("hold7", mk(0, 8'h80, 0, 8'h80, 3'd7, 1, 0));
    @(posedge clk);
    #2;
    areset_n = 1'b0;
    #1;
    chk_outs("async_rst", mk(0, 8'h80, 0, 8'h00, 3'd0, 0, 0));
    @(negedge clk);
    areset_n = 1'b1;
    bus.req  = 8'h81;
    @(posedge clk);
    #1;
    chk_outs("ptr_cleared", mk(0, 8'h81, 0, 8'h01, 3'd0, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
